// File: rtl/reg_file.sv
// reg_file: 32-entry general-purpose register file feeding the ALU.
// Two combinational read ports (src1/src2), one clocked write port,
// and a side-effect-free debug read port that always shows stored state.
// Register 0 reads as zero and ignores writes. The stack-pointer entry
// (SP_IDX) loads SP_RESET on reset instead of zero.
//
// Write port: a write is a single-cycle request with no handshake. When
// RegWrite_i is high at a rising clk_i edge, RDdata_i lands in
// reg[RDaddr_i]. There is no back-pressure; the file accepts every cycle.
module reg_file #(
  parameter int              DATA_W   = 32,
  parameter int              ADDR_W   = 5,
  parameter int              SP_IDX   = 29,
  parameter logic [DATA_W-1:0] SP_RESET = 128,
  parameter bit              BYPASS   = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] RSaddr_i,
  input  logic [ADDR_W-1:0] RTaddr_i,
  input  logic [ADDR_W-1:0] RDaddr_i,
  input  logic [DATA_W-1:0] RDdata_i,
  input  logic              RegWrite_i,
  output logic [DATA_W-1:0] RSdata_o,
  output logic [DATA_W-1:0] RTdata_o,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  output logic [DATA_W-1:0] dbg_data_o
);

  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREG];

  // A write to index 0 is dropped here so entry 0 stays at its reset value.
  logic write_en;
  assign write_en = RegWrite_i && (RDaddr_i != '0);

  // Storage: asynchronous reset loads the reset image; otherwise one write per edge.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= (i == SP_IDX) ? SP_RESET : '0;
      end
    end else if (write_en) begin
      regs[RDaddr_i] <= RDdata_i;
    end
  end

  // Stored value at an index, with index 0 forced to zero explicitly so the
  // read side does not depend on entry 0 never having been written.
  function automatic logic [DATA_W-1:0] stored(input logic [ADDR_W-1:0] idx);
    if (idx == '0) return '0;
    return regs[idx];
  endfunction

  // Operand read: optional write-through of the in-flight write, so an
  // instruction reading the register being written this cycle sees new data.
  // While reset is held the write is discarded, so no forwarding either.
  function automatic logic [DATA_W-1:0] operand(input logic [ADDR_W-1:0] idx);
    if (BYPASS && rst_i && write_en && (RDaddr_i == idx)) return RDdata_i;
    return stored(idx);
  endfunction

  // Combinational read ports; identical addresses give identical data.
  always_comb begin
    RSdata_o   = operand(RSaddr_i);
    RTdata_o   = operand(RTaddr_i);
    dbg_data_o = stored(dbg_addr_i);
  end

endmodule
